// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: byte-engine command encodings and write-sequencer states.
package i2c_pkg;

    localparam logic [2:0] CmdIdle  = 3'b000;
    localparam logic [2:0] CmdStart = 3'b001;
    localparam logic [2:0] CmdWrite = 3'b011;
    localparam logic [2:0] CmdStop  = 3'b100;
    localparam logic [2:0] CmdNack  = 3'b101;
    localparam logic [2:0] CmdAck   = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAck,
        StFetch,
        StData,
        StStop,
        StDone
    } wr_state_e;

    // Byte-engine command owned by a state; CmdIdle for states that do not drive the byte engine.
    function automatic logic [2:0] state_cmd(input wr_state_e st);
        case (st)
            StStart:        return CmdStart;
            StAddr, StData: return CmdWrite;
            StStop:         return CmdStop;
            default:        return CmdIdle;
        endcase
    endfunction

endpackage

// File: rtl/i2c_op_handshake.sv
// Two-phase go/finish handshake: raise go on start once finish is low, drop it when finish is seen.
module i2c_op_handshake (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    input  logic finish_i,
    output logic go_o,
    output logic op_done_o
);

    logic go_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            go_q <= 1'b0;
        end else if (!go_q && start_i && !finish_i) begin
            go_q <= 1'b1;
        end else if (go_q && finish_i) begin
            go_q <= 1'b0;
        end
    end

    assign go_o      = go_q;
    // Valid in the first cycle finish is seen high, so callers can sample engine results here.
    assign op_done_o = go_q && finish_i;

endmodule

// File: rtl/i2c_write_sequencer.sv
// Sequences START, address byte, N data bytes with ACK checks, then STOP for one I2C write.
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             done,
    output logic             error,
    output logic             eng_go,
    output logic [2:0]       eng_command,
    input  logic             eng_finish,
    input  logic             eng_load,
    output logic             eng_data,
    output logic             ack_go,
    input  logic             ack_finish,
    input  logic             ack_bit
);

    wr_state_e        state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             nack_q, nack_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             req_ready_q, wr_ready_q, done_q, error_q;
    logic             is_eng_op, eng_start, eng_done, ack_start, ack_done;

    assign is_eng_op = (state_cmd(state_q) != CmdIdle);
    // Hold off go until the registered command already matches, so it is stable before go rises.
    assign eng_start = is_eng_op && (cmd_q == state_cmd(state_q));
    assign ack_start = (state_q == StAck);

    i2c_op_handshake u_eng_hs (
        .clock     (clock),
        .reset     (reset),
        .start_i   (eng_start),
        .finish_i  (eng_finish),
        .go_o      (eng_go),
        .op_done_o (eng_done)
    );

    i2c_op_handshake u_ack_hs (
        .clock     (clock),
        .reset     (reset),
        .start_i   (ack_start),
        .finish_i  (ack_finish),
        .go_o      (ack_go),
        .op_done_o (ack_done)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        nack_d  = nack_q;
        shift_d = shift_q;
        cmd_d   = cmd_q;

        if (!eng_go && (is_eng_op || state_q == StIdle)) begin
            cmd_d = state_cmd(state_q);
        end

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    count_d = req_len;
                    nack_d  = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (eng_done) begin
                    shift_d = {addr_q, 1'b0};
                    state_d = StAddr;
                end
            end
            StAddr, StData: begin
                if (!eng_load) begin
                    shift_d = {shift_q[6:0], 1'b0};
                end
                if (eng_done) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (ack_done) begin
                    if (ack_bit) begin
                        nack_d  = 1'b1;
                        state_d = StStop;
                    end else if (count_q == '0) begin
                        state_d = StStop;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (wr_valid && wr_ready_q) begin
                    shift_d = wr_data;
                    count_d = count_q - LEN_W'(1);
                    state_d = StData;
                end
            end
            StStop: begin
                if (eng_done) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            count_q     <= '0;
            nack_q      <= 1'b0;
            shift_q     <= '0;
            cmd_q       <= CmdIdle;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            nack_q      <= nack_d;
            shift_q     <= shift_d;
            cmd_q       <= cmd_d;
            req_ready_q <= (state_d == StIdle);
            wr_ready_q  <= (state_d == StFetch);
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StDone) && nack_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign wr_ready    = wr_ready_q;
    assign done        = done_q;
    assign error       = error_q;
    assign eng_command = cmd_q;
    assign eng_data    = shift_q[7];

endmodule

// File: doc/i2c_write_sequencer.md
# i2c_write_sequencer

Transaction-level controller that sequences the I2C master bit/byte engines to perform one complete I2C write transfer: START, address byte with R/W=0, N data bytes each followed by a slave ACK check, then STOP. Sits between the bus-host request interface and the `I2C_master_write_byte` engine plus the master's single-bit receive engine. Owns the engine `go`/`command` handshake and the serial data shift register. Reports completion and slave NACK.

## Interface
- `LEN_W`, 4: width of byte-count field; max data bytes per transfer = 2^LEN_W − 1.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; engines receive `reset_n = ~reset` at top level.
- `req_valid`  in  1  transfer request.
- `req_ready`  out  1  high only in IDLE.
- `req_addr`  in  7  7-bit slave address.
- `req_len`  in  LEN_W  number of data bytes (0 = address-only probe).
- `wr_data`  in  8  next data byte.
- `wr_valid` / `wr_ready`  in / out  1  data byte handshake; transfer on both high.
- `done`  out  1  one-cycle pulse at end of transfer.
- `error`  out  1  valid with `done`; 1 = slave NACK seen.
- `eng_go`  out  1  byte engine go.
- `eng_command`  out  3  byte engine command.
- `eng_finish`  in  1  byte engine finish.
- `eng_load`  in  1  active-low shift strobe from engine.
- `eng_data`  out  1  serial bit to engine = shift register MSB.
- `ack_go`  out  1  receive-bit engine go.
- `ack_finish`  in  1  receive-bit engine finish.
- `ack_bit`  in  1  sampled SDA; 0 = ACK, 1 = NACK.

## Operation
- Engine commands: START 3'b001, WRITE_BYTE 3'b011, STOP 3'b100, NACK 3'b101, ACK 3'b111, IDLE 3'b000. This block uses START, WRITE_BYTE and STOP only.
- Engine handshake for every operation:
  - Assert `go` with a stable command.
  - Hold `go` until `finish` is sampled high, then drop `go`.
  - Wait for `finish` low before the next `go`.
  - `ack_go`/`ack_finish` follow the same rule.
- States: IDLE → START → ADDR → ACK → (FETCH → DATA → ACK)×len → STOP → DONE → IDLE.
- IDLE: on `req_valid`, latch `req_addr`/`req_len` into the address and count registers, clear the NACK flag, and go to START.
- START: run the START command.
- ADDR: load the shift register with `{req_addr, 1'b0}` before raising `go`, then run WRITE_BYTE.
- ACK: run the receive-bit op and sample `ack_bit` in the cycle `ack_finish` is first seen high.
  - On NACK: set the error flag and go to STOP.
  - On ACK with count 0: go to STOP.
  - On ACK otherwise: go to FETCH.
- FETCH: `wr_ready` = 1. On transfer, load the shift register with the byte, decrement the count, and go to DATA. The transfer may stall indefinitely; `eng_go` stays low meanwhile.
- DATA: run WRITE_BYTE, then go to ACK.
- STOP: run the STOP command. DONE: pulse `done`, drive `error` = flag, return to IDLE.
- Shift register: shift left one bit, zero-filling, on each cycle `eng_load` = 0 while in ADDR/DATA. It holds in all other states. `eng_data` = bit 7.

## Timing
- Reset values:
  - `req_ready` = 0 during reset, 1 the cycle after.
  - `eng_go` = 0, `ack_go` = 0, `eng_command` = 3'b000, `wr_ready` = 0.
  - `done` = 0, `error` = 0, `eng_data` = 0.
  - State = IDLE, shift register = 0.
- Reset mid-transfer aborts immediately: no STOP is issued, all outputs take reset values the next cycle, and the engines are reset in parallel.
- `eng_command` is registered and changes only while `eng_go` = 0. It returns to 3'b000 in IDLE.
- `go` rises at the earliest one cycle after entering an op state. The next op's `go` rises at the earliest one cycle after `finish` is seen low.
- `req_valid` is ignored outside IDLE. `req_ready` drops in the cycle after acceptance.
- `req_len` = 0: sequence is START, ADDR, ACK, STOP; FETCH is never entered.
- NACK on the address or any data byte: the remaining bytes are skipped and no further `wr_ready` is asserted.
- `done` and `error` last exactly one cycle. `error` is 0 whenever `done` is 0.

## Structure
- Shared package `i2c_pkg`: command encodings and the state enum/localparams. The byte engine and testbenches use the same package.
- One sub-module, `i2c_op_handshake`: the go/finish two-phase handshake. Interface: start, go, finish, op_done pulse. Instantiated twice, once per engine.

## Test plan
- Address-only probe: addr 7'h50, len 0, slave ACK → commands 001, 011 (serial 1010_0000), ack op, 100; `done` = 1, `error` = 0.
- Two-byte write: addr 7'h2A, data 8'hAC then 8'h35, all ACK → serial bits 0101_0100, 1010_1100, 0011_0101; exactly two `wr_valid`/`wr_ready` transfers.
- Address NACK: `ack_bit` = 1 on the first ack → STOP issued next, no FETCH, `done` = 1 with `error` = 1.
- Data stall: `wr_valid` held low 50 cycles in FETCH → `eng_go` stays 0; the transfer resumes correctly afterward.
- Handshake check: model `finish` low-return delayed 5 cycles → next `go` is never raised while `finish` is high.
- Reset mid-DATA → the next cycle shows all outputs at reset values; a new request then completes normally.
